bsg_comm_link_tx_arbiter: RTL

//  Shares the fused core-side input of the comm link (valid/data/ready) among
//  num_clients_p requesters. Round-robin arbitration at packet granularity: a

---
 rtl/bsg_comm_link_tx_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bsg_comm_link_tx_arbiter.sv
// Round-robin, packet-granular arbiter feeding the comm link core-side input; gated by link calibration.
// Latency: 0 cycles, combinational from the selected client flit to link_data_o/link_v_o.
// Backpressure: client_yumi_o fires only on link_v_o & link_ready_i; a stalled link holds the grant and burst count.
// Optional statistics counters are built when BSG_COMM_LINK_TX_ARB_STATS_EN is defined.
module bsg_comm_link_tx_arbiter #(
  parameter int num_clients_p = 4,
  parameter int width_p       = 80,
  parameter int len_width_p   = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 calib_done_i,
  input  logic [num_clients_p-1:0]             client_v_i,
  input  logic [num_clients_p*width_p-1:0]     client_data_i,
  output logic [num_clients_p-1:0]             client_yumi_o,
  output logic                                 link_v_o,
  output logic [width_p-1:0]                   link_data_o,
  input  logic                                 link_ready_i,
  output logic [$clog2(num_clients_p)-1:0]     grant_id_o,
  output logic                                 busy_o,
  output logic [31:0]                          stall_cnt_o,
  output logic [31:0]                          pkt_cnt_o
);

  localparam int id_w_lp = $clog2(num_clients_p);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [id_w_lp-1:0]     ptr_q, ptr_d;
  logic [id_w_lp-1:0]     lock_q, lock_d;
  logic [len_width_p-1:0] rem_q, rem_d;

  logic [width_p-1:0]     client_data_arr [num_clients_p];
  logic [id_w_lp-1:0]     arb_sel;
  logic [id_w_lp-1:0]     cand_id;
  logic                   arb_found;
  logic [id_w_lp-1:0]     sel;
  logic                   transfer;
  logic                   pkt_done;
  logic [len_width_p-1:0] hdr_len;

  for (genvar k = 0; k < num_clients_p; k++) begin : g_unpack
    assign client_data_arr[k] = client_data_i[k*width_p +: width_p];
  end

  // Round-robin pick: first valid client at or after ptr_q, wrapping; falls back to ptr_q
  always_comb begin
    arb_sel   = ptr_q;
    arb_found = 1'b0;
    cand_id   = '0;
    for (int i = 0; i < num_clients_p; i++) begin
      cand_id = id_w_lp'((int'(ptr_q) + i) % num_clients_p);
      if (!arb_found && client_v_i[cand_id]) begin
        arb_sel   = cand_id;
        arb_found = 1'b1;
      end
    end
  end

  // Link-side datapath: locked client owns the link for the whole burst, bubbles included
  always_comb begin
    sel         = (state_q == BURST) ? lock_q : arb_sel;
    link_v_o    = (state_q != IDLE) && client_v_i[sel];
    link_data_o = client_data_arr[sel];
    transfer    = link_v_o && link_ready_i;
    hdr_len     = link_data_o[len_width_p-1:0];
    grant_id_o  = (state_q == IDLE) ? ptr_q : sel;
    busy_o      = (state_q == BURST);
    for (int k = 0; k < num_clients_p; k++) begin
      client_yumi_o[k] = transfer && (sel == id_w_lp'(k));
    end
  end

  // Next-state: calibration loss aborts any packet; pointer advances only when a packet completes
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    rem_d    = rem_q;
    pkt_done = 1'b0;
    if (!calib_done_i) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARB;
        ARB: begin
          if (transfer) begin
            if (hdr_len != '0) begin
              state_d = BURST;
              rem_d   = hdr_len;
              lock_d  = sel;
            end else begin
              pkt_done = 1'b1;
            end
          end
        end
        BURST: begin
          if (transfer) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == len_width_p'(1)) begin
              state_d  = ARB;
              pkt_done = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (pkt_done) begin
      ptr_d = (sel == id_w_lp'(num_clients_p - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      rem_q   <= rem_d;
    end
  end

`ifdef BSG_COMM_LINK_TX_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  // Saturating counters; only reset clears them, calibration loss leaves them alone
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    if (link_v_o && !link_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (pkt_done && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign pkt_cnt_o   = pkt_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign pkt_cnt_o   = '0;
`endif

`ifndef SYNTHESIS
  // A client offering a flit on a calibrated link must hold it, unchanged, until consumed
  for (genvar k = 0; k < num_clients_p; k++) begin : g_hold_chk
    assert property (@(posedge clk_i) disable iff (reset_i)
      (calib_done_i && client_v_i[k] && !client_yumi_o[k])
      |=> (!calib_done_i || (client_v_i[k] && $stable(client_data_i[k*width_p +: width_p]))));
  end
`endif

endmodule
